// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rng_pkg
// Brief   : Shared constants, channel state type and seed salt for rng_multi.
// Revision: 1.0 - initial release
// ============================================================================
package rng_pkg;

  localparam int                LFSR_W    = 32;
  localparam logic [LFSR_W-1:0] TAPS      = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] SALT_STEP = 32'h9E37_79B9;
  localparam logic [LFSR_W-1:0] ZERO_SUB  = 32'h0000_0001;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    VALID = 1'b1
  } rng_state_e;

  // Channels 0/1 reduce to seed and ~seed, matching the older dual generator.
  function automatic logic [LFSR_W-1:0] chan_salt(input int unsigned k);
    logic [LFSR_W-1:0] odd_mask;
    logic [LFSR_W-1:0] pair_mix;
    odd_mask = k[0] ? '1 : '0;
    pair_mix = LFSR_W'(k >> 1) * SALT_STEP;
    return odd_mask ^ pair_mix;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rng_lfsr_step.sv
`default_nettype none
// ============================================================================
// Module  : rng_lfsr_step
// Brief   : One combinational step of the 32-bit Galois LFSR.
// Revision: 1.0 - initial release
// ============================================================================
module rng_lfsr_step
  import rng_pkg::*;
(
  input  logic [LFSR_W-1:0] s_in,
  output logic [LFSR_W-1:0] s_out,
  output logic              bit_out
);

  always_comb begin
    bit_out = s_in[0];
    s_out   = s_in >> 1;
    if (s_in[0]) begin
      s_out = s_out ^ TAPS;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rng_multi.sv
`default_nettype none
// ============================================================================
// Module  : rng_multi
// Brief   : NUM_CH independent LFSR channels delivering OUT_W-bit words over
//           valid/ready. Define RNG_HEALTH_EN to add the repetition test and
//           the health_fail port.
// Revision: 1.0 - initial release
// ============================================================================
module rng_multi
  import rng_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int OUT_W      = 8,
  parameter int REP_CUTOFF = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             seed,
  input  logic                    seed_load,
  output logic [NUM_CH*OUT_W-1:0] rnd_data,
  output logic [NUM_CH-1:0]       rnd_valid,
  input  logic [NUM_CH-1:0]       rnd_ready
`ifdef RNG_HEALTH_EN
  ,
  output logic [NUM_CH-1:0]       health_fail
`endif
);

  localparam int             CNT_W    = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_W - 1);

  if (NUM_CH < 1 || NUM_CH > 16 || OUT_W < 1 || OUT_W > 32 || REP_CUTOFF < 2) begin : g_param_check
    $error("rng_multi: parameter out of range");
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [LFSR_W-1:0] seed_raw;
    logic [LFSR_W-1:0] seed_k;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_cur, lfsr_nxt;
    logic              seeded_q, seeded_d;
    logic              nxt_bit;
    rng_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  word_q, word_d, word_shift;
    logic              xfer;

    assign seed_raw = seed ^ chan_salt(k);
    assign seed_k   = (seed_raw == '0) ? ZERO_SUB : seed_raw;

    // Until the first edge after reset release the seed port is the live state.
    assign lfsr_cur = seeded_q ? lfsr_q : seed_k;

    rng_lfsr_step u_step (
      .s_in    (lfsr_cur),
      .s_out   (lfsr_nxt),
      .bit_out (nxt_bit)
    );

    if (OUT_W == 1) begin : g_w1
      assign word_shift = nxt_bit;
    end else begin : g_wn
      assign word_shift = {word_q[OUT_W-2:0], nxt_bit};
    end

    assign xfer = (state_q == VALID) && rnd_ready[k];

    always_comb begin
      lfsr_d   = lfsr_q;
      seeded_d = seeded_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      if (seed_load) begin
        lfsr_d   = seed_k;
        seeded_d = 1'b1;
        state_d  = FILL;
        cnt_d    = '0;
        word_d   = '0;
      end else if (state_q == FILL) begin
        lfsr_d   = lfsr_nxt;
        seeded_d = 1'b1;
        word_d   = word_shift;
        if (cnt_q == LAST_BIT) begin
          state_d = VALID;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (xfer) begin
        state_d = FILL;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lfsr_q   <= '0;
        seeded_q <= 1'b0;
        state_q  <= FILL;
        cnt_q    <= '0;
        word_q   <= '0;
      end else begin
        lfsr_q   <= lfsr_d;
        seeded_q <= seeded_d;
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        word_q   <= word_d;
      end
    end

    assign rnd_data[k*OUT_W +: OUT_W] = word_q;
    assign rnd_valid[k]               = (state_q == VALID);

`ifdef RNG_HEALTH_EN
    localparam int REP_W = $clog2(REP_CUTOFF + 1);
    logic [OUT_W-1:0] last_q, last_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             fail_q, fail_d;

    always_comb begin
      last_d = last_q;
      rep_d  = rep_q;
      fail_d = fail_q | (rep_q >= REP_W'(REP_CUTOFF));
      if (seed_load) begin
        last_d = '0;
        rep_d  = '0;
        fail_d = 1'b0;
      end else if (xfer) begin
        last_d = word_q;
        // rep_q of zero means no word has been transferred since reseed.
        if ((rep_q != '0) && (word_q == last_q)) begin
          if (rep_q < REP_W'(REP_CUTOFF)) begin
            rep_d = rep_q + REP_W'(1);
          end
        end else begin
          rep_d = REP_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        last_q <= '0;
        rep_q  <= '0;
        fail_q <= 1'b0;
      end else begin
        last_q <= last_d;
        rep_q  <= rep_d;
        fail_q <= fail_d;
      end
    end

    assign health_fail[k] = fail_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_rng_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_rng_multi
// Brief   : Directed self-checking bench for rng_multi (NUM_CH=2, OUT_W=4),
//           plus a 1-bit health-test instance when RNG_HEALTH_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rng_multi;

  localparam int N = 2;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [31:0]    seed;
  logic           seed_load;
  logic [N*W-1:0] rnd_data;
  logic [N-1:0]   rnd_valid;
  logic [N-1:0]   rnd_ready;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RNG_HEALTH_EN
  logic [N-1:0] health_fail;
  logic         hc_reset, hc_seed_load, hc_ready;
  logic         hc_data, hc_valid, hc_fail;
`endif

  rng_multi #(
    .NUM_CH     (N),
    .OUT_W      (W),
    .REP_CUTOFF (4)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .seed        (seed),
    .seed_load   (seed_load),
    .rnd_data    (rnd_data),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready)
`ifdef RNG_HEALTH_EN
    ,
    .health_fail (health_fail)
`endif
  );

`ifdef RNG_HEALTH_EN
  rng_multi #(
    .NUM_CH     (1),
    .OUT_W      (1),
    .REP_CUTOFF (2)
  ) u_hc (
    .clk         (clk),
    .reset       (hc_reset),
    .seed        (seed),
    .seed_load   (hc_seed_load),
    .rnd_data    (hc_data),
    .rnd_valid   (hc_valid),
    .rnd_ready   (hc_ready),
    .health_fail (hc_fail)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR: produces one W-bit word, first bit in the MSB.
  function automatic logic [W-1:0] mdl_word(inout logic [31:0] s);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      w = {w[W-2:0], s[0]};
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    end
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0]  m0, m1;
    logic [W-1:0] exp0, exp1, dummy;
    int           stable_err, ch1_xfers, ch1_err, vmiss, err0, err1;

    reset     = 1'b0;
    seed      = 32'h1;
    seed_load = 1'b0;
    rnd_ready = 2'b11;
`ifdef RNG_HEALTH_EN
    hc_reset     = 1'b0;
    hc_seed_load = 1'b0;
    hc_ready     = 1'b0;
`endif
    #12;
    chk("rst_valid", 32'(rnd_valid), 32'h0);
    chk("rst_data",  32'(rnd_data),  32'h0);
`ifdef RNG_HEALTH_EN
    chk("rst_health", 32'(health_fail), 32'h0);
`endif

    // T1: first words after reset release
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();
    chk("t1_latency", 32'(rnd_valid), 32'h0);
    tick();
    chk("t1_valid", 32'(rnd_valid), 32'h3);
    chk("t1_ch0_w0", 32'(rnd_data[3:0]), 32'hD);
    chk("t1_ch1_w0", 32'(rnd_data[7:4]), 32'h4);
    tick();
    chk("t1_xfer_drop", 32'(rnd_valid), 32'h0);
    repeat (3) tick();
    chk("t1_refill", 32'(rnd_valid), 32'h0);
    tick();
    chk("t1_valid2", 32'(rnd_valid), 32'h3);
    chk("t1_ch0_w1", 32'(rnd_data[3:0]), 32'hB);
    chk("t1_ch1_w1", 32'(rnd_data[7:4]), 32'h9);

    // T2: stall ch0 for 20 cycles while ch1 streams
    m0 = 32'h1;
    m1 = 32'hFFFF_FFFE;
    dummy = mdl_word(m0);
    dummy = mdl_word(m0);
    dummy = mdl_word(m1);
    dummy = mdl_word(m1);
    exp1 = 4'h9;
    stable_err = 0;
    ch1_xfers  = 0;
    ch1_err    = 0;
    rnd_ready  = 2'b10;
    for (int i = 0; i < 20; i++) begin
      if (rnd_valid[1]) begin
        if (rnd_data[7:4] !== exp1) ch1_err++;
        ch1_xfers++;
        exp1 = mdl_word(m1);
      end
      tick();
      if (rnd_valid[0] !== 1'b1 || rnd_data[3:0] !== 4'hB) stable_err++;
    end
    chk("t2_ch0_stable", 32'(stable_err), 32'd0);
    chk("t2_ch1_xfers",  32'(ch1_xfers),  32'd4);
    chk("t2_ch1_data",   32'(ch1_err),    32'd0);
    chk("t2_ch1_pend",   32'(rnd_data[7:4]), 32'(exp1));
    rnd_ready = 2'b11;
    tick();
    chk("t2_release_drop", 32'(rnd_valid[0]), 32'h0);
    exp0 = mdl_word(m0);
    repeat (4) tick();
    chk("t2_one_xfer_valid", 32'(rnd_valid[0]), 32'h1);
    chk("t2_one_xfer_word",  32'(rnd_data[3:0]), 32'(exp0));

    // T3: seed_load with ch0 two bits into a word
    tick();
    tick();
    tick();
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("t3_load_valid", 32'(rnd_valid), 32'h0);
    chk("t3_load_data",  32'(rnd_data),  32'h0);
    repeat (3) tick();
    chk("t3_latency", 32'(rnd_valid), 32'h0);
    tick();
    chk("t3_valid",  32'(rnd_valid), 32'h3);
    chk("t3_ch0_w0", 32'(rnd_data[3:0]), 32'hD);
    chk("t3_ch1_w0", 32'(rnd_data[7:4]), 32'h4);

    // T4: zero seed, long run against the reference
    seed      = 32'h0;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    m0 = 32'h0000_0001;
    m1 = 32'hFFFF_FFFF;
    vmiss = 0;
    err0  = 0;
    err1  = 0;
    for (int w = 0; w < 1000; w++) begin
      repeat ((w == 0) ? 4 : 5) tick();
      exp0 = mdl_word(m0);
      exp1 = mdl_word(m1);
      if (rnd_valid !== 2'b11) vmiss++;
      if (rnd_data[3:0] !== exp0) err0++;
      if (rnd_data[7:4] !== exp1) err1++;
      if (w == 0) begin
        chk("t4_ch0_first", 32'(rnd_data[3:0]), 32'hD);
        chk("t4_ch1_first", 32'(rnd_data[7:4]), 32'h9);
      end
    end
    chk("t4_valid_miss", 32'(vmiss), 32'd0);
    chk("t4_ch0_stream", 32'(err0),  32'd0);
    chk("t4_ch1_stream", 32'(err1),  32'd0);

    // T5: asynchronous reset during VALID
    seed      = 32'h1;
    rnd_ready = 2'b00;
    chk("t5_pre_valid", 32'(rnd_valid), 32'h3);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async_valid", 32'(rnd_valid), 32'h0);
    chk("t5_async_data",  32'(rnd_data),  32'h0);
    @(negedge clk);
    reset     = 1'b1;
    rnd_ready = 2'b11;
    repeat (4) tick();
    chk("t5_valid",  32'(rnd_valid), 32'h3);
    chk("t5_ch0_w0", 32'(rnd_data[3:0]), 32'hD);
    chk("t5_ch1_w0", 32'(rnd_data[7:4]), 32'h4);
    repeat (5) tick();
    chk("t5_ch0_w1", 32'(rnd_data[3:0]), 32'hB);
    chk("t5_ch1_w1", 32'(rnd_data[7:4]), 32'h9);

`ifdef RNG_HEALTH_EN
    // T6: 1-bit words 1,1 trip a cutoff of 2
    @(negedge clk);
    hc_reset = 1'b1;
    hc_ready = 1'b1;
    tick();
    chk("t6_w0_valid", 32'(hc_valid), 32'h1);
    chk("t6_w0_data",  32'(hc_data),  32'h1);
    tick();
    tick();
    chk("t6_w1_data",  32'(hc_data),  32'h1);
    chk("t6_no_fail",  32'(hc_fail),  32'h0);
    tick();
    tick();
    tick();
    chk("t6_fail_set", 32'(hc_fail), 32'h1);
    hc_ready = 1'b0;
    repeat (5) tick();
    chk("t6_fail_held", 32'(hc_fail), 32'h1);
    hc_seed_load = 1'b1;
    tick();
    hc_seed_load = 1'b0;
    chk("t6_fail_clear", 32'(hc_fail), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
